// File: rtl/fp_addsub_pkg.sv
// rtl/fp_addsub_pkg.sv - shared types, flag indices and special-value patterns for fp_addsub_param
package fp_addsub_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_ROUND
  } fp_state_e;

  typedef enum logic [1:0] {
    FP_ZERO,
    FP_NORM,
    FP_INF,
    FP_NAN
  } fp_class_e;

  localparam int FLG_INV = 3;
  localparam int FLG_OVF = 2;
  localparam int FLG_UNF = 1;
  localparam int FLG_INX = 0;

  // Patterns are built in a wide vector and truncated by the caller to 1+exp_w+man_w bits.
  localparam int FP_MAX_W = 128;

  function automatic logic [FP_MAX_W-1:0] fp_qnan(input int exp_w, input int man_w);
    logic [FP_MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < exp_w; i++) begin
      v[man_w+i] = 1'b1;
    end
    v[man_w-1] = 1'b1;
    return v;
  endfunction

  function automatic logic [FP_MAX_W-1:0] fp_inf(input logic sign, input int exp_w, input int man_w);
    logic [FP_MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < exp_w; i++) begin
      v[man_w+i] = 1'b1;
    end
    v[exp_w+man_w] = sign;
    return v;
  endfunction

endpackage

// File: rtl/fp_addsub_param_lzc.sv
// rtl/fp_addsub_param_lzc.sv - combinational leading-zero counter (fp_lzc); all-zero input returns WIDTH
import fp_addsub_pkg::*;

module fp_lzc #(
  parameter int WIDTH = 27,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] i_data,
  output logic [CNT_W-1:0] o_cnt
);

  logic w_found;

  always_comb begin
    o_cnt   = CNT_W'(WIDTH);
    w_found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!w_found && i_data[i]) begin
        o_cnt   = CNT_W'(WIDTH - 1 - i);
        w_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_addsub_param.sv
// rtl/fp_addsub_param.sv - multi-cycle parametrised IEEE-754 add/subtract, RNE, flush-to-zero
import fp_addsub_pkg::*;

module fp_addsub_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic                   op,
  input  logic                   load,
  output logic                   busy,
  output logic                   done,
  output logic [EXP_W+MAN_W:0]   sum,
  output logic [3:0]             status
);

  localparam int W       = 1 + EXP_W + MAN_W;
  localparam int MX      = MAN_W + 4;
  localparam int LZ_W    = $clog2(MX + 1);
  localparam int XW      = ((EXP_W > LZ_W) ? EXP_W : LZ_W) + 2;
  localparam int EXP_MAX = (1 << EXP_W) - 1;
  localparam logic [31:0] SH_MAX = 32'(MAN_W + 3);

  fp_state_e r_state, w_next;

  logic [W-1:0]       r_a, r_b;
  logic               r_sa, r_sb;
  logic [EXP_W-1:0]   r_ea, r_eb;
  logic [MAN_W:0]     r_ma, r_mb;
  logic               r_spec, r_spec_inv;
  logic [W-1:0]       r_spec_val;
  logic               r_sign, r_sub;
  logic [EXP_W-1:0]   r_exp;
  logic [MX-1:0]      r_mbig, r_msml;
  logic [MX:0]        r_msum;
  logic signed [XW-1:0] r_nexp;
  logic [MX-1:0]      r_nman;
  logic               r_nzero;
  logic [W-1:0]       r_sum;
  logic [3:0]         r_status;
  logic               r_done;

  function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
    if (e == '0) return FP_ZERO;
    if (&e) return (f == '0) ? FP_INF : FP_NAN;
    return FP_NORM;
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (load) w_next = S_UNPACK;
      S_UNPACK: w_next = S_ALIGN;
      S_ALIGN:  w_next = S_ADD;
      S_ADD:    w_next = S_NORM;
      S_NORM:   w_next = S_ROUND;
      S_ROUND:  w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Unpack: classification and special-result decision.
  logic               w_sa, w_sb;
  logic [EXP_W-1:0]   w_ea, w_eb;
  logic [MAN_W-1:0]   w_fa, w_fb;
  fp_class_e          w_ca, w_cb;
  logic               w_snan_a, w_snan_b;
  logic               w_spec, w_spec_inv;
  logic [W-1:0]       w_spec_val;

  assign {w_sa, w_ea, w_fa} = r_a;
  assign {w_sb, w_eb, w_fb} = r_b;
  assign w_ca     = classify(w_ea, w_fa);
  assign w_cb     = classify(w_eb, w_fb);
  assign w_snan_a = (w_ca == FP_NAN) && !w_fa[MAN_W-1];
  assign w_snan_b = (w_cb == FP_NAN) && !w_fb[MAN_W-1];

  always_comb begin
    w_spec     = 1'b0;
    w_spec_inv = 1'b0;
    w_spec_val = '0;
    if (w_ca == FP_NAN || w_cb == FP_NAN) begin
      w_spec     = 1'b1;
      w_spec_inv = w_snan_a | w_snan_b;
      w_spec_val = W'(fp_qnan(EXP_W, MAN_W));
    end else if (w_ca == FP_INF && w_cb == FP_INF && w_sa != w_sb) begin
      w_spec     = 1'b1;
      w_spec_inv = 1'b1;
      w_spec_val = W'(fp_qnan(EXP_W, MAN_W));
    end else if (w_ca == FP_INF) begin
      w_spec     = 1'b1;
      w_spec_val = W'(fp_inf(w_sa, EXP_W, MAN_W));
    end else if (w_cb == FP_INF) begin
      w_spec     = 1'b1;
      w_spec_val = W'(fp_inf(w_sb, EXP_W, MAN_W));
    end
  end

  // Align: larger magnitude first; the smaller one is shifted through a double-width window
  // so every bit that falls out can be ORed into sticky.
  logic               w_a_ge;
  logic               w_s_big;
  logic [EXP_W-1:0]   w_e_big, w_e_sml, w_diff;
  logic [MAN_W:0]     w_m_big, w_m_sml;
  logic [31:0]        w_sh;
  logic [2*MX-1:0]    w_wide;
  logic [MX-1:0]      w_sml_al;

  assign w_a_ge   = {r_ea, r_ma} >= {r_eb, r_mb};
  assign w_s_big  = w_a_ge ? r_sa : r_sb;
  assign w_e_big  = w_a_ge ? r_ea : r_eb;
  assign w_e_sml  = w_a_ge ? r_eb : r_ea;
  assign w_m_big  = w_a_ge ? r_ma : r_mb;
  assign w_m_sml  = w_a_ge ? r_mb : r_ma;
  assign w_diff   = w_e_big - w_e_sml;
  assign w_sh     = (32'(w_diff) > SH_MAX) ? SH_MAX : 32'(w_diff);
  assign w_wide   = {w_m_sml, 3'b000, {MX{1'b0}}} >> w_sh;
  assign w_sml_al = {w_wide[2*MX-1:MX+1], w_wide[MX] | (|w_wide[MX-1:0])};

  // Normalise.
  logic [LZ_W-1:0]      w_lz;
  logic [MX-1:0]        w_nman;
  logic signed [XW-1:0] w_nexp;

  fp_lzc #(
    .WIDTH (MX),
    .CNT_W (LZ_W)
  ) u_lzc (
    .i_data (r_msum[MX-1:0]),
    .o_cnt  (w_lz)
  );

  always_comb begin
    if (r_msum[MX]) begin
      w_nman = {r_msum[MX:2], r_msum[1] | r_msum[0]};
      w_nexp = $signed(XW'(r_exp)) + $signed(XW'(1));
    end else begin
      w_nman = r_msum[MX-1:0] << w_lz;
      w_nexp = $signed(XW'(r_exp)) - $signed(XW'(w_lz));
    end
  end

  // Round to nearest even, then pack with overflow/underflow handling.
  logic                 w_g, w_r, w_s, w_rup, w_inx;
  logic [MAN_W+1:0]     w_mr;
  logic signed [XW-1:0] w_rexp;
  logic [MAN_W-1:0]     w_frac;
  logic [W-1:0]         w_res;
  logic [3:0]           w_flags;

  assign w_g    = r_nman[2];
  assign w_r    = r_nman[1];
  assign w_s    = r_nman[0];
  assign w_inx  = w_g | w_r | w_s;
  assign w_rup  = w_g & (w_r | w_s | r_nman[3]);
  assign w_mr   = {1'b0, r_nman[MX-1:3]} + {{(MAN_W+1){1'b0}}, w_rup};
  assign w_rexp = w_mr[MAN_W+1] ? r_nexp + $signed(XW'(1)) : r_nexp;
  assign w_frac = w_mr[MAN_W+1] ? w_mr[MAN_W:1] : w_mr[MAN_W-1:0];

  always_comb begin
    w_res   = '0;
    w_flags = '0;
    if (r_spec) begin
      w_res            = r_spec_val;
      w_flags[FLG_INV] = r_spec_inv;
    end else if (r_nzero) begin
      // Only (-0)+(-0) keeps a negative sign; cancellation yields +0.
      w_res = {r_sign & ~r_sub, {(W-1){1'b0}}};
    end else if (w_rexp >= $signed(XW'(EXP_MAX))) begin
      w_res            = W'(fp_inf(r_sign, EXP_W, MAN_W));
      w_flags[FLG_OVF] = 1'b1;
      w_flags[FLG_INX] = 1'b1;
    end else if (w_rexp[XW-1] || w_rexp == '0) begin
      w_res            = {r_sign, {(W-1){1'b0}}};
      w_flags[FLG_UNF] = 1'b1;
      w_flags[FLG_INX] = 1'b1;
    end else begin
      w_res            = {r_sign, w_rexp[EXP_W-1:0], w_frac};
      w_flags[FLG_INX] = w_inx;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_a        <= '0;
      r_b        <= '0;
      r_sa       <= 1'b0;
      r_sb       <= 1'b0;
      r_ea       <= '0;
      r_eb       <= '0;
      r_ma       <= '0;
      r_mb       <= '0;
      r_spec     <= 1'b0;
      r_spec_inv <= 1'b0;
      r_spec_val <= '0;
      r_sign     <= 1'b0;
      r_sub      <= 1'b0;
      r_exp      <= '0;
      r_mbig     <= '0;
      r_msml     <= '0;
      r_msum     <= '0;
      r_nexp     <= '0;
      r_nman     <= '0;
      r_nzero    <= 1'b0;
      r_sum      <= '0;
      r_status   <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (load) begin
            r_a <= a;
            r_b <= {b[W-1] ^ op, b[W-2:0]};
          end
        end
        S_UNPACK: begin
          // Zero and subnormal operands both become exponent 0, mantissa 0.
          r_sa       <= w_sa;
          r_sb       <= w_sb;
          r_ea       <= (w_ca == FP_ZERO) ? '0 : w_ea;
          r_eb       <= (w_cb == FP_ZERO) ? '0 : w_eb;
          r_ma       <= (w_ca == FP_ZERO) ? '0 : {1'b1, w_fa};
          r_mb       <= (w_cb == FP_ZERO) ? '0 : {1'b1, w_fb};
          r_spec     <= w_spec;
          r_spec_inv <= w_spec_inv;
          r_spec_val <= w_spec_val;
        end
        S_ALIGN: begin
          r_sign <= w_s_big;
          r_sub  <= r_sa ^ r_sb;
          r_exp  <= w_e_big;
          r_mbig <= {w_m_big, 3'b000};
          r_msml <= w_sml_al;
        end
        S_ADD: begin
          r_msum <= r_sub ? ({1'b0, r_mbig} - {1'b0, r_msml})
                          : ({1'b0, r_mbig} + {1'b0, r_msml});
        end
        S_NORM: begin
          r_nman  <= w_nman;
          r_nexp  <= w_nexp;
          r_nzero <= (r_msum == '0);
        end
        S_ROUND: begin
          r_sum    <= w_res;
          r_status <= w_flags;
          r_done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = r_done;
  assign sum    = r_sum;
  assign status = r_status;

endmodule
